// File: rtl/reg_rename_file_if.sv
// Issue/commit/read-port bundle between the rename register file and the core.
// master = decoder/ROB/issue side, slave = register file.
interface reg_rename_file_if #(
   parameter int XLEN    = 32,
   parameter int ID_BIT  = 5,
   parameter int ROB_BIT = 4,
   parameter int NREAD   = 2
);
   logic                     rdy_in;
   logic                     flush_in;
   logic                     commit_valid;
   logic [ID_BIT-1:0]        commit_id;
   logic [XLEN-1:0]          commit_data;
   logic [ROB_BIT-1:0]       commit_rob;
   logic                     issue_valid;
   logic [ID_BIT-1:0]        issue_id;
   logic [ROB_BIT-1:0]       issue_rob;
   logic [NREAD*ID_BIT-1:0]  rd_id;
   logic [NREAD*XLEN-1:0]    rd_val;
   logic [NREAD-1:0]         rd_has_dep;
   logic [NREAD*ROB_BIT-1:0] rd_dep;
   logic [NREAD*ROB_BIT-1:0] rob_query;
   logic [NREAD-1:0]         rob_ready;
   logic [NREAD*XLEN-1:0]    rob_value;

   modport master (
      output rdy_in, flush_in,
      output commit_valid, commit_id, commit_data, commit_rob,
      output issue_valid, issue_id, issue_rob,
      output rd_id, rob_ready, rob_value,
      input  rd_val, rd_has_dep, rd_dep, rob_query
   );

   modport slave (
      input  rdy_in, flush_in,
      input  commit_valid, commit_id, commit_data, commit_rob,
      input  issue_valid, issue_id, issue_rob,
      input  rd_id, rob_ready, rob_value,
      output rd_val, rd_has_dep, rd_dep, rob_query
   );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register dirty bit and ROB tag for renaming.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards same-cycle commit data to matching reads.
module reg_rename_file #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ID_BIT   = 5,
   parameter int ROB_BIT  = 4,
   parameter int NREAD    = 2
) (
   input logic clk_in,
   input logic rst_in,
   reg_rename_file_if.slave bus
);

   logic [XLEN-1:0]    r_regs  [NUM_REGS];
   logic               r_dirty [NUM_REGS];
   logic [ROB_BIT-1:0] r_tag   [NUM_REGS];

   logic [ID_BIT-1:0]  w_rd_id     [NREAD];
   logic [NREAD-1:0]   w_byp;
   logic               w_commit_en;
   logic               w_commit_clr;
   logic               w_issue_en;

   always_comb begin
      for (int unsigned k = 0; k < NREAD; k++) begin
         w_rd_id[k] = bus.rd_id[k*ID_BIT +: ID_BIT];
      end
   end

   always_comb begin
      w_byp = '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
      for (int unsigned k = 0; k < NREAD; k++) begin
         w_byp[k] = bus.commit_valid && (bus.commit_id == w_rd_id[k]) &&
                    (bus.commit_rob == r_tag[w_rd_id[k]]);
      end
`endif
   end

   // Reads see pre-update state; dirty qualifies the tag (tag 0 is a real ROB entry).
   always_comb begin
      bus.rd_val     = '0;
      bus.rd_has_dep = '0;
      bus.rd_dep     = '0;
      bus.rob_query  = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         bus.rob_query[k*ROB_BIT +: ROB_BIT] = r_tag[w_rd_id[k]];
         if (w_rd_id[k] == '0) begin
            bus.rd_val[k*XLEN +: XLEN] = '0;
         end else if (r_dirty[w_rd_id[k]]) begin
            if (w_byp[k]) begin
               bus.rd_val[k*XLEN +: XLEN] = bus.commit_data;
            end else if (bus.rob_ready[k]) begin
               bus.rd_val[k*XLEN +: XLEN] = bus.rob_value[k*XLEN +: XLEN];
            end else begin
               bus.rd_has_dep[k]                = 1'b1;
               bus.rd_dep[k*ROB_BIT +: ROB_BIT] = r_tag[w_rd_id[k]];
            end
         end else begin
            bus.rd_val[k*XLEN +: XLEN] = r_regs[w_rd_id[k]];
         end
      end
   end

   assign w_commit_en  = bus.commit_valid && (bus.commit_id != '0);
   assign w_commit_clr = w_commit_en && r_dirty[bus.commit_id] &&
                         (r_tag[bus.commit_id] == bus.commit_rob);
   assign w_issue_en   = bus.issue_valid && (bus.issue_id != '0) && !bus.flush_in;

   // Issue is applied after the commit clear so a same-register rename wins.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_regs[i]  <= '0;
            r_dirty[i] <= 1'b0;
            r_tag[i]   <= '0;
         end
      end else if (bus.rdy_in) begin
         if (w_commit_en) begin
            r_regs[bus.commit_id] <= bus.commit_data;
         end
         if (bus.flush_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               r_dirty[i] <= 1'b0;
               r_tag[i]   <= '0;
            end
         end else begin
            if (w_commit_clr) begin
               r_dirty[bus.commit_id] <= 1'b0;
               r_tag[bus.commit_id]   <= '0;
            end
            if (w_issue_en) begin
               r_dirty[bus.issue_id] <= 1'b1;
               r_tag[bus.issue_id]   <= bus.issue_rob;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file (two read ports, default sizes).
module tb_reg_rename_file;

   localparam int XLEN = 32;
   localparam int IDB  = 5;
   localparam int RB   = 4;
   localparam int NR   = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   reg_rename_file_if #(.XLEN(XLEN), .ID_BIT(IDB), .ROB_BIT(RB), .NREAD(NR)) bus ();

   reg_rename_file #(
      .XLEN(XLEN), .NUM_REGS(32), .ID_BIT(IDB), .ROB_BIT(RB), .NREAD(NR)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush_in     = 1'b0;
      bus.commit_valid = 1'b0;
      bus.commit_id    = '0;
      bus.commit_data  = '0;
      bus.commit_rob   = '0;
      bus.issue_valid  = 1'b0;
      bus.issue_id     = '0;
      bus.issue_rob    = '0;
      bus.rob_ready    = '0;
      bus.rob_value    = '0;
   endtask

   task automatic rd(input int k, input logic [IDB-1:0] id);
      bus.rd_id[k*IDB +: IDB] = id;
   endtask

   task automatic issue(input logic [IDB-1:0] id, input logic [RB-1:0] rob);
      bus.issue_valid = 1'b1;
      bus.issue_id    = id;
      bus.issue_rob   = rob;
   endtask

   task automatic commit(input logic [IDB-1:0] id, input logic [RB-1:0] rob,
                         input logic [XLEN-1:0] data);
      bus.commit_valid = 1'b1;
      bus.commit_id    = id;
      bus.commit_rob   = rob;
      bus.commit_data  = data;
   endtask

   function automatic logic [31:0] val(input int k);
      return bus.rd_val[k*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] dep(input int k);
      return 32'(bus.rd_dep[k*RB +: RB]);
   endfunction

   function automatic logic [31:0] qry(input int k);
      return 32'(bus.rob_query[k*RB +: RB]);
   endfunction

   function automatic logic [31:0] hd(input int k);
      return 32'(bus.rd_has_dep[k]);
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.rdy_in = 1'b1;
      bus.rd_id  = '0;
      idle();
      // 1. reset
      cyc(); cyc();
      rst_n = 1'b1;
      rd(0, 5'd5); rd(1, 5'd0);
      #1;
      chk("rst_val0", val(0), 32'h0);
      chk("rst_dep0", hd(0), 32'h0);
      chk("rst_val1", val(1), 32'h0);
      chk("rst_dep1", hd(1), 32'h0);
      chk("rst_qry0", qry(0), 32'h0);
      chk("rst_tag0", dep(0), 32'h0);

      // 2. rename then resolve; same-cycle issue invisible to reads
      issue(5'd3, 4'd7);
      rd(0, 5'd3);
      #1;
      chk("iss_invis", hd(0), 32'h0);
      cyc(); idle();
      rd(1, 5'd3);
      #1;
      chk("ren_hd", hd(0), 32'h1);
      chk("ren_dep", dep(0), 32'h7);
      chk("ren_qry", qry(0), 32'h7);
      chk("ren_val", val(0), 32'h0);
      bus.rob_ready[0] = 1'b1;
      bus.rob_value[0*XLEN +: XLEN] = 32'hDEADBEEF;
      #1;
      chk("res_val", val(0), 32'hDEADBEEF);
      chk("res_hd", hd(0), 32'h0);
      chk("res_p1_hd", hd(1), 32'h1);

      // 3. stale commit ignored
      idle(); issue(5'd4, 4'd2); cyc();
      idle(); issue(5'd4, 4'd5); cyc();
      idle(); commit(5'd4, 4'd2, 32'd11); cyc();
      idle(); rd(0, 5'd4);
      #1;
      chk("stale_hd", hd(0), 32'h1);
      chk("stale_dep", dep(0), 32'h5);
      commit(5'd4, 4'd5, 32'd11); cyc(); idle();
      #1;
      chk("x4_val", val(0), 32'd11);
      chk("x4_hd", hd(0), 32'h0);

      // 4. simultaneous issue/commit on one register
      issue(5'd6, 4'd3); cyc(); idle();
      commit(5'd6, 4'd3, 32'd9); issue(5'd6, 4'd4); cyc(); idle();
      rd(0, 5'd6);
      #1;
      chk("sim_hd", hd(0), 32'h1);
      chk("sim_dep", dep(0), 32'h4);
      commit(5'd6, 4'd4, 32'd9); cyc(); idle();
      #1;
      chk("sim_val", val(0), 32'd9);

      // 5. flush with commit and issue
      issue(5'd8, 4'd1); cyc(); idle();
      bus.flush_in = 1'b1;
      commit(5'd8, 4'd1, 32'd42); issue(5'd9, 4'd2); cyc(); idle();
      rd(0, 5'd8); rd(1, 5'd9);
      #1;
      chk("fl_val8", val(0), 32'd42);
      chk("fl_hd8", hd(0), 32'h0);
      chk("fl_hd9", hd(1), 32'h0);
      chk("fl_qry9", qry(1), 32'h0);
      // flush also drops a pending rename with no matching commit
      issue(5'd12, 4'd6); cyc(); idle();
      bus.flush_in = 1'b1; cyc(); idle();
      rd(1, 5'd12);
      #1;
      chk("fl_hd12", hd(1), 32'h0);

      // 6. rdy low freezes state, reads stay live; x0 writes ignored
      bus.rdy_in = 1'b0;
      commit(5'd2, 4'd0, 32'd5); issue(5'd2, 4'd6); rd(1, 5'd2);
      #1;
      chk("rdy0_live", val(0), 32'd42);
      cyc(); cyc(); idle();
      bus.rdy_in = 1'b1;
      #1;
      chk("rdy0_val", val(1), 32'd0);
      chk("rdy0_hd", hd(1), 32'h0);
      commit(5'd0, 4'd0, 32'd77); issue(5'd0, 4'd3); cyc(); idle();
      rd(0, 5'd0);
      #1;
      chk("x0_val", val(0), 32'd0);
      chk("x0_hd", hd(0), 32'h0);
      chk("x0_qry", qry(0), 32'h0);

      // tag 0 is a real ROB entry
      issue(5'd11, 4'd0); cyc(); idle();
      rd(0, 5'd11);
      #1;
      chk("tag0_hd", hd(0), 32'h1);
      chk("tag0_dep", dep(0), 32'h0);

      // commit bypass on a dirty read
      issue(5'd10, 4'd9); cyc(); idle();
      rd(1, 5'd10);
      commit(5'd10, 4'd9, 32'h55);
      #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
      chk("byp_val", val(1), 32'h55);
      chk("byp_hd", hd(1), 32'h0);
`else
      chk("nobyp_hd", hd(1), 32'h1);
      chk("nobyp_dep", dep(1), 32'h9);
      bus.rob_ready[1] = 1'b1;
      bus.rob_value[1*XLEN +: XLEN] = 32'h55;
      #1;
      chk("nobyp_val", val(1), 32'h55);
`endif
      cyc(); idle();
      #1;
      chk("x10_val", val(1), 32'h55);
      chk("x10_hd", hd(1), 32'h0);

      // reset mid-run clears everything
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      rd(0, 5'd4); rd(1, 5'd11);
      #1;
      chk("rst2_val4", val(0), 32'h0);
      chk("rst2_hd11", hd(1), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
Parametrised architectural register file with rename-status tracking for the out-of-order core, sitting between decoder, ROB and RS/LSB issue logic.
- Holds committed register values, a per-register dirty bit and a per-register ROB tag.
- Serves NREAD source-operand lookups per cycle; each lookup is resolved against the ROB ready/value query ports.
- Accepts one issue (rename) and one commit per cycle, plus a global flush on misprediction.

Parameters:
XLEN, 32, register data width
NUM_REGS, 32, architectural register count (power of two; x0 hardwired zero)
ID_BIT, 5, register index width, equals log2(NUM_REGS)
ROB_BIT, 4, ROB entry index width
NREAD, 2, number of source-operand read ports

Ports:
clk_in  in  1  system clock, all state updates on rising edge
rst_in  in  1  reset; synchronous, active-low
rdy_in  in  1  ready; state frozen when low
flush_in  in  1  ROB clear-up (misprediction)
commit_valid  in  1  ROB commits a register write this cycle
commit_id  in  ID_BIT  destination register of commit
commit_data  in  XLEN  committed value
commit_rob  in  ROB_BIT  ROB entry being committed
issue_valid  in  1  decoder issues an instruction with a destination register
issue_id  in  ID_BIT  destination register of issued instruction
issue_rob  in  ROB_BIT  ROB entry allocated to it
rd_id  in  NREAD*ID_BIT  source register index per port, port k at bits [k*ID_BIT +: ID_BIT]
rd_val  out  NREAD*XLEN  operand value per port
rd_has_dep  out  NREAD  operand still waiting on ROB
rd_dep  out  NREAD*ROB_BIT  ROB tag waited on (valid when rd_has_dep)
rob_query  out  NREAD*ROB_BIT  tag sent to ROB per port
rob_ready  in  NREAD  ROB entry has its result
rob_value  in  NREAD*XLEN  ROB entry result

Behaviour:
- Reset (rst_in==0 at clock edge): all regs, dirty bits and tags cleared to 0. Outputs are combinational from state, so after reset every port reads val=0, has_dep=0, dep=0, rob_query=0.
- Read port k is purely combinational, zero latency, and sees state before this cycle's issue/commit. Priority order:
  - id==0: val=0, has_dep=0, dep=0.
  - Else if dirty[id]: rob_query=tag[id].
    - If rob_ready: val=rob_value, has_dep=0.
    - Else: val=0, has_dep=1, dep=tag[id].
  - Else: val=regs[id], has_dep=0.
  - rob_query=tag[id] on every port regardless of dirty.
- Same-cycle issue is never visible to read ports. The instruction being issued reads its own sources from pre-rename state.
- Commit, when rdy_in=1 and commit_valid=1 and commit_id!=0:
  - regs[commit_id] <= commit_data.
  - If dirty[commit_id] and tag[commit_id]==commit_rob: clear dirty and tag, unless the same-cycle issue targets the same register.
  - A tag mismatch (a younger writer exists) leaves dirty/tag unchanged.
- Issue, when rdy_in=1, issue_valid=1, issue_id!=0 and no flush: dirty[issue_id] <= 1, tag[issue_id] <= issue_rob.
  - Issue wins over commit clearing on the same register.
- Flush (rdy_in=1, flush_in=1):
  - All dirty bits and tags cleared.
  - A same-cycle commit still writes regs.
  - A same-cycle issue is discarded.
- rdy_in=0: no state change; read ports remain live.
- Writes to x0 via commit or issue are ignored; regs[0] stays 0.
- Tag 0 is a legal ROB entry. Dirty alone qualifies a tag.

Optional Feature:
Macro: REGFILE_COMMIT_BYPASS_EN
- Defined: a read port whose id is dirty with tag equal to a same-cycle valid commit (commit_id==id, commit_rob==tag[id]) returns val=commit_data, has_dep=0. The ROB response is ignored for that port.
- Undefined: no bypass. The read resolves only through rob_ready/rob_value, and the ROB must keep the committing entry readable that cycle.

Test Plan:
1. Reset → rst_in=0 for 2 cycles, then read ports 0,1 at x5, x0 → val=0, has_dep=0 on both ports; all state zero.
2. Rename then resolve → issue x3 → rob 7, next cycle read x3 with rob_ready=0 → has_dep=1, dep=7, rob_query=7. Then rob_ready=1, rob_value=0xDEADBEEF → val=0xDEADBEEF, has_dep=0.
3. Stale commit ignored → issue x4→rob 2, then issue x4→rob 5, then commit x4, rob 2, data 11 → regs[4]=11, dirty[4]=1, tag[4]=5.
4. Simultaneous issue/commit on one register → x6 dirty with tag 3; in one cycle commit x6/rob 3/data 9 and issue x6/rob 4 → regs[6]=9, dirty=1, tag=4.
5. Flush with commit/issue → x8 dirty tag 1; one cycle with flush_in=1, commit x8/rob 1/data 42, issue x9/rob 2 → x8 reads 42 with no dep; x9 not dirty.
6. rdy_in low and x0 writes → rdy_in=0 with commit x2/data 5 → no change. Commit x0/data 77 with rdy_in=1 → x0 reads 0. With REGFILE_COMMIT_BYPASS_EN, reading a dirty x10 during its matching commit of data 0x55 → val=0x55 regardless of rob_ready.
